hack_mem_arbiter: RTL and testbench
===================================

# hack_mem_arbiter

Parametrised N-channel memory arbiter between the Hack CPU, the VGA scan-out engine and future bus masters, such as a DMA or the seven-segment/LCD mirrors, and the single SDRAM command port of `ram_manager`. It replaces the fixed two-way CPU/GPU address mux. It adds:
- per-channel request/acknowledge handshakes;
- a real-time window in which only channel 0 (display) is served, read-only;
- round-robin fairness among the remaining channels;
- in-order read-return routing through a tag FIFO.

## Interface
Parameters:
- `CH`, 4, number of client channels (≥2); channel 0 is the real-time (display) channel.
- `AW`, 20, address width.
- `DW`, 16, data width.
- `RD_DEPTH`, 4, maximum outstanding reads (tag FIFO depth, power of two ≥2).

Ports:
- `clk50` in 1: sole clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state.
- `req` in CH: per-channel request level.
- `we` in CH: per-channel write (1) / read (0), valid with `req`.
- `addr` in CH*AW: packed addresses, channel i at bits [i*AW +: AW].
- `wdata` in CH*DW: packed write data, channel i at [i*DW +: DW].
- `rt_window` in 1: real-time window (display area active).
- `ack` out CH: one-cycle grant pulse per channel.
- `rvalid` out CH: one-cycle read-return pulse per channel.
- `rdata` out DW: read data, valid while any `rvalid` bit is high.
- `mem_cmd_valid` out 1: command presented to the memory port.
- `mem_ready` in 1: memory port accepts a command (buffer empty).
- `mem_we`, `mem_addr` (AW), `mem_wdata` (DW) out: the held command.
- `mem_rvalid` in 1, `mem_rdata` in DW: in-order read returns from memory.
- `busy` out 1: command pending or tag FIFO non-empty.
- `err_orphan` out 1: sticky flag, a read return arrived with no outstanding tag.

## Operation
- **Eligibility:** channel i is eligible when `req[i]`=1 and all of the following hold:
  - a read needs the tag FIFO not full;
  - while `rt_window`=1, only channel 0 with `we[0]`=0 is eligible, and all writes are held off.
- **States:**
  - IDLE (`mem_cmd_valid`=0) → ISSUE when any channel is eligible.
  - ISSUE → IDLE on the cycle `mem_cmd_valid`&`mem_ready`.
  - Arbitration occurs only in IDLE.
- **Priority:**
  - Eligible channel 0 always wins.
  - Otherwise, round-robin over channels 1..CH-1 starting at pointer `rr`.
  - Granting channel k≥1 sets `rr` = k+1, wrapping CH→1.
  - Granting channel 0 leaves `rr` unchanged.
- **On grant:** the winner's we/addr/wdata are latched into the `mem_*` registers, `mem_cmd_valid`←1, and `ack[k]`←1 for exactly one cycle.
- **Client rule:** deassert or replace `req` in the cycle after `ack` is seen; the arbiter never re-grants within the ISSUE window.
- **On transfer of a read:** push the channel index (clog2(CH) bits) into the tag FIFO.
- **On `mem_rvalid`:** pop the tag, pulse `rvalid[tag]`, and register `rdata`←`mem_rdata`.
- **Simultaneous push and pop:** allowed, occupancy unchanged. Full + push cannot occur (reads are ineligible when full).
- **`mem_rvalid` with empty FIFO:** no `rvalid` pulse; `err_orphan`←1 until reset.
- **`rt_window` rising while in ISSUE:** the held command (a write included) still completes; only new grants are restricted.
- **Writes:** no return path. `ack` is the only completion indication.

## Timing
- **Reset values:** `ack`, `rvalid`, `rdata`, `mem_cmd_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `err_orphan` are all 0; `rr`=1; tag FIFO empty.
- **Grant latency:** `req` eligible in IDLE at cycle t → `mem_cmd_valid` and `ack` high at t+1.
- **ISSUE duration:** `mem_cmd_valid` stays high until the first cycle with `mem_ready`=1 (inclusive), then is 0 the next cycle. Minimum command spacing is 2 cycles.
- **Read-return latency:** `mem_rvalid` at cycle r → `rvalid`/`rdata` at r+1. Back-to-back returns are supported every cycle.
- **Reset mid-operation:** the pending command is dropped and tags are discarded. A late return after reset sets `err_orphan`, so `ram_manager` must be reset together with this block.
- **Pointer width:** `rr` and tag width are clog2(CH). FIFO pointers are clog2(RD_DEPTH)+1 bits with wrap-around.

## Test plan
- **Single read:** reset, then ch2 read addr 0x00123, `mem_ready`=1 → `ack[2]` at t+1, `mem_addr`=0x00123, `mem_we`=0. `mem_rvalid` with 0xBEEF → `rvalid[2]`=1, `rdata`=0xBEEF one cycle later.
- **Round-robin:** ch1/ch2/ch3 request continuously (re-raising after each ack), ch0 idle → grant order 1,2,3,1,2,3. Then raise ch0 → ch0 wins the next grant and the rotation resumes where it left off.
- **Real-time window:** `rt_window`=1 with ch0 read, ch1 write and ch3 read pending → only ch0 is granted. After `rt_window`=0, ch1 then ch3 are granted.
- **Tag FIFO full:** with `RD_DEPTH`=4, issue 4 reads (ch1,ch3,ch1,ch2) and no returns → a 5th read is stalled while a pending write still issues. Returns route to `rvalid` bits 1,3,1,2 in that order.
- **Memory backpressure and orphan:** hold `mem_ready`=0 for 5 cycles → `mem_cmd_valid` and command stay stable with no further `ack`. Then pulse `mem_rvalid` with the FIFO empty → `err_orphan`=1, no `rvalid`.
- **Reset mid-operation:** assert `reset` low mid-ISSUE with 2 tags outstanding → all outputs are 0 immediately (asynchronous) and `busy`=0 after release.

Source files
------------

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter: N-channel SDRAM command arbiter with a real-time display window, round-robin fairness and in-order read-return routing
//   clk50, reset                 : clock, asynchronous active-low reset
//   req, we, addr, wdata         : per-channel requests, channel i packed at [i*W +: W]
//   rt_window                    : while high only channel-0 reads may be granted
//   ack, rvalid, rdata           : grant pulse, read-return pulse, returned data
//   mem_cmd_valid .. mem_wdata   : held command toward the memory port (mem_ready accepts)
//   mem_rvalid, mem_rdata        : in-order read returns from memory
//   busy, err_orphan             : activity flag, sticky unmatched-return flag
module hack_mem_arbiter #(
  parameter int CH = 4,
  parameter int AW = 20,
  parameter int DW = 16,
  parameter int RD_DEPTH = 4
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic [CH-1:0]    req,
  input  logic [CH-1:0]    we,
  input  logic [CH*AW-1:0] addr,
  input  logic [CH*DW-1:0] wdata,
  input  logic             rt_window,
  output logic [CH-1:0]    ack,
  output logic [CH-1:0]    rvalid,
  output logic [DW-1:0]    rdata,
  output logic             mem_cmd_valid,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_rvalid,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             err_orphan
);
  localparam int TW = $clog2(CH);
  localparam int PW = $clog2(RD_DEPTH) + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [TW-1:0] rr, mem_ch, win, k;
  logic [PW-1:0] wp, rp;
  logic [TW-1:0] tags [RD_DEPTH];
  logic [CH-1:0] elig;
  logic found, full, empty, push;
  assign empty = wp == rp;
  assign full = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign push = state == ISSUE && mem_ready && !mem_we;
  assign mem_cmd_valid = state == ISSUE;
  assign busy = mem_cmd_valid || !empty;
  // Channel 0 has absolute priority; otherwise scan 1..CH-1 starting at rr.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CH; i++)
      elig[i] = req[i] && (we[i] ? !rt_window : !full) && (i == 0 || !rt_window);
    found = elig[0];
    win = '0;
    k = rr;
    for (int j = 0; j < CH - 1; j++) begin
      if (!found && elig[k]) begin
        found = 1'b1;
        win = k;
      end
      k = (k == TW'(CH - 1)) ? TW'(1) : k + 1'b1;
    end
  end
  always_ff @(posedge clk50 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rr <= TW'(1);
      mem_ch <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ack <= '0;
      rvalid <= '0;
      rdata <= '0;
      err_orphan <= 1'b0;
      wp <= '0;
      rp <= '0;
    end else begin
      ack <= '0;
      rvalid <= '0;
      if (state == IDLE && found) begin
        state <= ISSUE;
        mem_ch <= win;
        mem_we <= we[win];
        mem_addr <= addr[win*AW +: AW];
        mem_wdata <= wdata[win*DW +: DW];
        ack[win] <= 1'b1;
        if (win != '0) rr <= (win == TW'(CH - 1)) ? TW'(1) : win + 1'b1;
      end else if (state == ISSUE && mem_ready) state <= IDLE;
      if (push) wp <= wp + 1'b1;
      // A return with no outstanding tag is dropped and flagged.
      if (mem_rvalid) begin
        rdata <= mem_rdata;
        if (empty) err_orphan <= 1'b1;
        else begin
          rvalid[tags[rp[PW-2:0]]] <= 1'b1;
          rp <= rp + 1'b1;
        end
      end
    end
  always_ff @(posedge clk50)
    if (push) tags[wp[PW-2:0]] <= mem_ch;
endmodule

// File: tb/tb_hack_mem_arbiter.sv
// tb_hack_mem_arbiter: directed scenarios plus random traffic checked against a queue-based model
module tb_hack_mem_arbiter;
  localparam int CH = 4, AW = 20, DW = 16, RD = 4;
  logic clk50 = 0, reset = 0;
  logic [CH-1:0] req = '0, we = '0;
  logic [CH*AW-1:0] addr = '0;
  logic [CH*DW-1:0] wdata = '0;
  logic rt_window = 0, mem_ready = 0, mem_rvalid = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic [CH-1:0] ack, rvalid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_cmd_valid, mem_we, busy, err_orphan;
  int checks = 0, errors = 0;
  bit pend, m_we, err;
  int m_ch, rr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int q[$], glog[$], rlog[$], expq[$];
  hack_mem_arbiter #(.CH(CH), .AW(AW), .DW(DW), .RD_DEPTH(RD)) dut (
    .clk50(clk50), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rt_window(rt_window), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .err_orphan(err_orphan)
  );
  always #10 clk50 = ~clk50;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_seq(string tag, int got[$], int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) check(tag, got[i], exp[i]);
  endtask
  function automatic bit elig(int i);
    return req[i] && (i == 0 || !rt_window) && (we[i] ? !rt_window : q.size() < RD);
  endfunction
  task automatic set_req(int c, bit w);
    req[c] = 1'b1;
    we[c] = w;
    addr[c*AW +: AW] = AW'($urandom);
    wdata[c*DW +: DW] = DW'($urandom);
  endtask
  task automatic step();
    int win = -1, rv = -1, k;
    logic [DW-1:0] rd = mem_rdata;
    if (!pend) begin
      if (elig(0)) win = 0;
      k = rr;
      repeat (CH - 1) begin
        if (win < 0 && elig(k)) win = k;
        k = (k == CH - 1) ? 1 : k + 1;
      end
    end
    if (mem_rvalid) begin
      if (q.size() > 0) rv = q.pop_front();
      else err = 1;
    end
    if (pend && mem_ready) begin
      if (!m_we) q.push_back(m_ch);
      pend = 0;
    end else if (win >= 0) begin
      pend = 1;
      m_ch = win;
      m_we = we[win];
      m_addr = addr[win*AW +: AW];
      m_wdata = wdata[win*DW +: DW];
      if (win > 0) rr = (win == CH - 1) ? 1 : win + 1;
    end
    @(posedge clk50);
    #1;
    check("ack", ack, win >= 0 ? (1 << win) : 0);
    check("rvalid", rvalid, rv >= 0 ? (1 << rv) : 0);
    if (rv >= 0) check("rdata", rdata, rd);
    check("cmd_valid", mem_cmd_valid, pend);
    if (pend) begin
      check("mem_we", mem_we, m_we);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    check("busy", busy, pend || q.size() > 0);
    check("err_orphan", err_orphan, err);
    for (int c = 0; c < CH; c++) begin
      if (ack[c]) glog.push_back(c);
      if (rvalid[c]) rlog.push_back(c);
    end
  endtask
  task automatic do_reset();
    reset = 0;
    req = '0;
    we = '0;
    rt_window = 0;
    mem_ready = 0;
    mem_rvalid = 0;
    pend = 0;
    q.delete();
    rr = 1;
    err = 0;
    @(posedge clk50);
    @(posedge clk50);
    #1 reset = 1;
  endtask
  task automatic read_then_drop(int c);
    set_req(c, 0);
    step();
    req[c] = 0;
    step();
  endtask
  initial begin
    do_reset();
    check("rst_ack", ack, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cmd_valid", mem_cmd_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_orphan, 0);
    // single read on channel 2
    mem_ready = 1;
    set_req(2, 0);
    addr[2*AW +: AW] = 20'h00123;
    step();
    check("sr_ack", ack, 4);
    check("sr_addr", mem_addr, 20'h00123);
    check("sr_we", mem_we, 0);
    req[2] = 0;
    step();
    mem_rvalid = 1;
    mem_rdata = 16'hBEEF;
    step();
    mem_rvalid = 0;
    check("sr_rvalid", rvalid, 4);
    check("sr_rdata", rdata, 16'hBEEF);
    // round-robin over 1..3, then channel 0 interjects
    do_reset();
    mem_ready = 1;
    glog.delete();
    for (int c = 1; c < CH; c++) set_req(c, 1);
    for (int n = 0; n < 40 && glog.size() < 9; n++) begin
      step();
      for (int c = 1; c < CH; c++) if (ack[c]) set_req(c, 1);
      if (ack[0]) req[0] = 0;
      if (ack != 0 && glog.size() == 6) set_req(0, 0);
    end
    expq = {1, 2, 3, 1, 2, 3, 0, 1, 2};
    check_seq("rr_order", glog, expq);
    // real-time window
    do_reset();
    mem_ready = 1;
    rt_window = 1;
    glog.delete();
    set_req(0, 0);
    set_req(1, 1);
    set_req(3, 0);
    for (int n = 0; n < 12; n++) begin
      step();
      for (int c = 0; c < CH; c++) if (ack[c]) req[c] = 0;
      if (n == 3) begin
        check("rt_only_ch0", glog.size(), 1);
        rt_window = 0;
      end
    end
    expq = {0, 1, 3};
    check_seq("rt_order", glog, expq);
    // tag FIFO full
    do_reset();
    mem_ready = 1;
    read_then_drop(1);
    read_then_drop(3);
    read_then_drop(1);
    read_then_drop(2);
    glog.delete();
    set_req(3, 0);
    set_req(2, 1);
    for (int n = 0; n < 6; n++) begin
      step();
      if (ack[2]) req[2] = 0;
    end
    expq = {2};
    check_seq("full_stall", glog, expq);
    req[3] = 0;
    rlog.delete();
    mem_rvalid = 1;
    for (int n = 0; n < 4; n++) begin
      mem_rdata = DW'($urandom);
      step();
    end
    mem_rvalid = 0;
    expq = {1, 3, 1, 2};
    check_seq("ret_route", rlog, expq);
    // backpressure then orphan return
    do_reset();
    set_req(1, 1);
    step();
    req[1] = 0;
    set_req(2, 1);
    glog.delete();
    repeat (5) step();
    check("bp_no_ack", glog.size(), 0);
    check("bp_valid", mem_cmd_valid, 1);
    req[2] = 0;
    mem_ready = 1;
    step();
    mem_ready = 0;
    mem_rvalid = 1;
    step();
    mem_rvalid = 0;
    check("orphan_err", err_orphan, 1);
    check("orphan_rvalid", rvalid, 0);
    // reset mid-ISSUE with two tags outstanding
    do_reset();
    mem_ready = 1;
    read_then_drop(1);
    read_then_drop(2);
    mem_ready = 0;
    set_req(3, 0);
    step();
    req[3] = 0;
    #5 reset = 0;
    #1;
    check("mid_ack", ack, 0);
    check("mid_cmd_valid", mem_cmd_valid, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_mem_wdata", mem_wdata, 0);
    check("mid_busy", busy, 0);
    check("mid_rvalid", rvalid, 0);
    pend = 0;
    q.delete();
    rr = 1;
    err = 0;
    @(posedge clk50);
    #1 reset = 1;
    step();
    check("mid_busy_after", busy, 0);
    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 10 == 0) rt_window = ~rt_window;
      mem_ready = ($urandom % 4) != 0;
      mem_rvalid = q.size() > 0 && ($urandom % 3 == 0);
      mem_rdata = DW'($urandom);
      step();
      for (int c = 0; c < CH; c++) begin
        if (ack[c]) begin
          if ($urandom % 2) set_req(c, 1'($urandom));
          else req[c] = 0;
        end else if (!req[c] && $urandom % 4 == 0) set_req(c, 1'($urandom));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
